// File: rtl/battle_pkg.sv
// Shared battle-box definitions: bullet colour codes, resolver FSM states
// and default hit strengths.
package battle_pkg;

   localparam logic [2:0] COLOR_WHITE  = 3'd0;
   localparam logic [2:0] COLOR_GREEN  = 3'd1;
   localparam logic [2:0] COLOR_BLUE   = 3'd2;
   localparam logic [2:0] COLOR_ORANGE = 3'd3;

   localparam int DEFAULT_ATTACK_POWER = 10;
   localparam int DEFAULT_HEAL_POWER   = 5;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } resolver_state_t;

endpackage

// File: rtl/sat_add.sv
// Unsigned saturating adder: the result clamps to all-ones instead of wrapping.
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   logic [W:0] full_s;

   assign full_s = {1'b0, a} + {1'b0, b};
   assign sum    = full_s[W] ? {W{1'b1}} : full_s[W-1:0];

endmodule

// File: rtl/damage_resolver.sv
// Per-frame bullet scan: walks every slot once, accumulating saturating damage
// and heal totals, and manages post-hit invincibility frames.
module damage_resolver
   import battle_pkg::*;
#(
   parameter int NUM_SLOTS    = 3,
   parameter int DMG_W        = 8,
   parameter int ATTACK_POWER = DEFAULT_ATTACK_POWER,
   parameter int HEAL_POWER   = DEFAULT_HEAL_POWER,
   parameter int IFRAME_SCANS = 2,
   parameter int IDX_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             isCollide,
   input  logic             isRender,
   input  logic             isMove,
   input  logic [2:0]       color,
   output logic [IDX_W-1:0] index,
   output logic [DMG_W-1:0] damage,
   output logic [DMG_W-1:0] healAmount,
   output logic [IDX_W:0]   hitCount,
   output logic             busy,
   output logic             done,
   output logic             invincible
);

   localparam longint     MAX_VAL  = (64'd1 << DMG_W) - 64'd1;
   localparam int         IF_W     = (IFRAME_SCANS > 0) ? $clog2(IFRAME_SCANS + 1) : 1;
   // Strengths larger than the accumulator range are clamped so one hit saturates.
   localparam logic [DMG_W-1:0] ATK_ADD  = (longint'(ATTACK_POWER) > MAX_VAL) ?
                                           {DMG_W{1'b1}} : DMG_W'(ATTACK_POWER);
   localparam logic [DMG_W-1:0] HEAL_ADD = (longint'(HEAL_POWER) > MAX_VAL) ?
                                           {DMG_W{1'b1}} : DMG_W'(HEAL_POWER);
   localparam logic [IF_W-1:0]  IF_LOAD  = IF_W'(IFRAME_SCANS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

   resolver_state_t  state_r;
   logic [IDX_W-1:0] index_r;
   logic [DMG_W-1:0] damage_r;
   logic [DMG_W-1:0] heal_r;
   logic [IDX_W:0]   hit_r;
   logic             busy_r;
   logic             done_r;
   logic             invincible_r;
   logic [IF_W-1:0]  iframe_r;

   logic             collide_s;
   logic             dmg_hit_s;
   logic             heal_hit_s;
   logic [DMG_W-1:0] dmg_add_s;
   logic [DMG_W-1:0] heal_add_s;
   logic [DMG_W-1:0] dmg_sum_s;
   logic [DMG_W-1:0] heal_sum_s;
   logic [IDX_W:0]   hit_next_s;
   logic [IF_W-1:0]  iframe_next_s;

   assign collide_s = isCollide & isRender;

   // Classify the addressed slot by colour and player movement.
   always_comb begin
      dmg_hit_s  = 1'b0;
      heal_hit_s = 1'b0;
      if (collide_s) begin
         case (color)
            COLOR_WHITE:  dmg_hit_s  = 1'b1;
            COLOR_GREEN:  heal_hit_s = 1'b1;
            COLOR_BLUE:   dmg_hit_s  = isMove;
            COLOR_ORANGE: dmg_hit_s  = ~isMove;
            default: begin
               dmg_hit_s  = 1'b0;
               heal_hit_s = 1'b0;
            end
         endcase
      end else begin
         dmg_hit_s  = 1'b0;
         heal_hit_s = 1'b0;
      end
   end

   // Hits during i-frames still count but deal nothing.
   assign dmg_add_s  = (dmg_hit_s && (iframe_r == {IF_W{1'b0}})) ? ATK_ADD : {DMG_W{1'b0}};
   assign heal_add_s = heal_hit_s ? HEAL_ADD : {DMG_W{1'b0}};
   assign hit_next_s = hit_r + ((dmg_hit_s | heal_hit_s) ? {{IDX_W{1'b0}}, 1'b1}
                                                         : {(IDX_W + 1){1'b0}});

   sat_add #(.W(DMG_W)) u_dmg_add (
      .a   (damage_r),
      .b   (dmg_add_s),
      .sum (dmg_sum_s)
   );

   sat_add #(.W(DMG_W)) u_heal_add (
      .a   (heal_r),
      .b   (heal_add_s),
      .sum (heal_sum_s)
   );

   // I-frame counter value to commit when the scan completes.
   assign iframe_next_s = (dmg_sum_s != {DMG_W{1'b0}}) ? IF_LOAD :
                          (iframe_r != {IF_W{1'b0}})   ? iframe_r - {{(IF_W - 1){1'b0}}, 1'b1} :
                                                         iframe_r;

   // Scan FSM with index, totals, hit count and i-frame bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         index_r      <= {IDX_W{1'b0}};
         damage_r     <= {DMG_W{1'b0}};
         heal_r       <= {DMG_W{1'b0}};
         hit_r        <= {(IDX_W + 1){1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         invincible_r <= 1'b0;
         iframe_r     <= {IF_W{1'b0}};
      end else begin
         done_r <= 1'b0;
         if (start) begin
            // A start in either state (re)begins the scan from slot 0.
            state_r  <= ST_SCAN;
            index_r  <= {IDX_W{1'b0}};
            damage_r <= {DMG_W{1'b0}};
            heal_r   <= {DMG_W{1'b0}};
            hit_r    <= {(IDX_W + 1){1'b0}};
            busy_r   <= 1'b1;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_IDLE;
               end
               ST_SCAN: begin
                  damage_r <= dmg_sum_s;
                  heal_r   <= heal_sum_s;
                  hit_r    <= hit_next_s;
                  if (index_r == LAST_IDX) begin
                     state_r      <= ST_IDLE;
                     index_r      <= {IDX_W{1'b0}};
                     busy_r       <= 1'b0;
                     done_r       <= 1'b1;
                     iframe_r     <= iframe_next_s;
                     invincible_r <= (iframe_next_s != {IF_W{1'b0}});
                  end else begin
                     index_r <= index_r + {{(IDX_W - 1){1'b0}}, 1'b1};
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign index      = index_r;
   assign damage     = damage_r;
   assign healAmount = heal_r;
   assign hitCount   = hit_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign invincible = invincible_r;

endmodule

// File: tb/tb_damage_resolver.sv
// Directed bench for damage_resolver: a default 3-slot instance plus an
// 8-slot, high-power, no-i-frame instance for saturation.
module tb_damage_resolver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Instance A: defaults
   logic       start_a = 1'b0;
   logic       move_a = 1'b0;
   logic       coll_a [4];
   logic       rend_a [4];
   logic [2:0] col_a  [4];
   logic       isCollide_a, isRender_a;
   logic [2:0] color_a;
   logic [1:0] index_a;
   logic [7:0] damage_a, heal_a;
   logic [2:0] hit_a;
   logic       busy_a, done_a, inv_a;

   assign isCollide_a = coll_a[index_a];
   assign isRender_a  = rend_a[index_a];
   assign color_a     = col_a[index_a];

   damage_resolver u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .isCollide(isCollide_a), .isRender(isRender_a), .isMove(move_a), .color(color_a),
      .index(index_a), .damage(damage_a), .healAmount(heal_a), .hitCount(hit_a),
      .busy(busy_a), .done(done_a), .invincible(inv_a)
   );

   // Instance B: 8 slots, power 40, no i-frames
   logic       start_b = 1'b0;
   logic       coll_b [8];
   logic [2:0] index_b;
   logic [7:0] damage_b, heal_b;
   logic [3:0] hit_b;
   logic       busy_b, done_b, inv_b;
   logic       isCollide_b;

   assign isCollide_b = coll_b[index_b];

   damage_resolver #(.NUM_SLOTS(8), .ATTACK_POWER(40), .IFRAME_SCANS(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .isCollide(isCollide_b), .isRender(1'b1), .isMove(1'b0), .color(3'd0),
      .index(index_b), .damage(damage_b), .healAmount(heal_b), .hitCount(hit_b),
      .busy(busy_b), .done(done_b), .invincible(inv_b)
   );

   task automatic set_slot_a(input int i, input logic c, input logic r, input logic [2:0] k);
      coll_a[i] = c;
      rend_a[i] = r;
      col_a[i]  = k;
   endtask

   task automatic clear_slots_a();
      for (int i = 0; i < 4; i++) set_slot_a(i, 1'b0, 1'b0, 3'd0);
   endtask

   // Pulse start on A (caller sits just after an edge) and count cycles to done.
   task automatic scan_a(output int lat);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      lat = 0;
      while (!done_a && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic scan_b(output int lat);
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      lat = 0;
      while (!done_b && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({damage_a, heal_a, hit_a, index_a, busy_a, done_a, inv_a} !== 24'd0) begin
         errors++;
         $display("FAIL reset_a: got dmg=%0d heal=%0d hit=%0d idx=%0d busy=%b done=%b inv=%b, want all 0",
                  damage_a, heal_a, hit_a, index_a, busy_a, done_a, inv_a);
      end
      checks++;
      if ({damage_b, heal_b, hit_b, index_b, busy_b, done_b, inv_b} !== 26'd0) begin
         errors++;
         $display("FAIL reset_b: got dmg=%0d hit=%0d busy=%b done=%b, want all 0",
                  damage_b, hit_b, busy_b, done_b);
      end
   endtask

   task automatic test_basic();
      int lat;
      clear_slots_a();
      set_slot_a(0, 1'b1, 1'b1, 3'd0);
      set_slot_a(1, 1'b1, 1'b1, 3'd1);
      set_slot_a(2, 1'b1, 1'b1, 3'd2);
      move_a = 1'b1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      checks++;
      if (busy_a !== 1'b1 || index_a !== 2'd0) begin
         errors++;
         $display("FAIL basic_busy: got busy=%b idx=%0d, want busy=1 idx=0", busy_a, index_a);
      end
      lat = 1;
      while (!done_a && lat < 20) begin
         @(posedge clk); #1;
         if (!done_a) lat++;
      end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
      checks++;
      if (damage_a !== 8'd20 || heal_a !== 8'd5 || hit_a !== 3'd3) begin
         errors++;
         $display("FAIL basic_totals: got dmg=%0d heal=%0d hit=%0d, want 20/5/3", damage_a, heal_a, hit_a);
      end
      checks++;
      if (inv_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_inv: got inv=%b busy=%b, want inv=1 busy=0", inv_a, busy_a);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      scan_a(lat);  // start raised in the done cycle of the previous scan
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL b2b_latency: got %0d want 3", lat); end
      checks++;
      if (damage_a !== 8'd0 || heal_a !== 8'd5 || hit_a !== 3'd3 || inv_a !== 1'b1) begin
         errors++;
         $display("FAIL b2b_iframe: got dmg=%0d heal=%0d hit=%0d inv=%b, want 0/5/3/1",
                  damage_a, heal_a, hit_a, inv_a);
      end
      clear_slots_a();
      scan_a(lat);
      checks++;
      if (damage_a !== 8'd0 || hit_a !== 3'd0 || heal_a !== 8'd0 || inv_a !== 1'b0 || lat !== 3) begin
         errors++;
         $display("FAIL b2b_expire: got dmg=%0d hit=%0d heal=%0d inv=%b lat=%0d, want 0/0/0/0/3",
                  damage_a, hit_a, heal_a, inv_a, lat);
      end
      @(posedge clk); #1;
      checks++;
      if (done_a !== 1'b0 || hit_a !== 3'd0) begin
         errors++;
         $display("FAIL done_width: got done=%b hit=%0d one cycle later, want done=0 hit=0", done_a, hit_a);
      end
   endtask

   task automatic test_orange_render();
      int lat;
      clear_slots_a();
      set_slot_a(0, 1'b1, 1'b1, 3'd3);
      move_a = 1'b0;
      scan_a(lat);
      checks++;
      if (damage_a !== 8'd10 || hit_a !== 3'd1 || inv_a !== 1'b1) begin
         errors++;
         $display("FAIL orange_still: got dmg=%0d hit=%0d inv=%b, want 10/1/1", damage_a, hit_a, inv_a);
      end
      set_slot_a(1, 1'b1, 1'b0, 3'd0);
      set_slot_a(2, 1'b1, 1'b1, 3'd6);
      move_a = 1'b1;
      scan_a(lat);
      checks++;
      if (damage_a !== 8'd0 || hit_a !== 3'd0 || heal_a !== 8'd0 || inv_a !== 1'b1) begin
         errors++;
         $display("FAIL orange_moving: got dmg=%0d hit=%0d heal=%0d inv=%b, want 0/0/0/1",
                  damage_a, hit_a, heal_a, inv_a);
      end
      clear_slots_a();
      scan_a(lat);
      checks++;
      if (inv_a !== 1'b0) begin errors++; $display("FAIL orange_expire: got inv=%b want 0", inv_a); end
   endtask

   task automatic test_abort();
      int lat;
      int extra_done;
      clear_slots_a();
      set_slot_a(0, 1'b1, 1'b1, 3'd0);
      set_slot_a(1, 1'b1, 1'b1, 3'd0);
      set_slot_a(2, 1'b1, 1'b1, 3'd1);
      move_a = 1'b0;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      @(posedge clk); #1;
      scan_a(lat);  // restart at the midpoint
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL abort_latency: got %0d want 3", lat); end
      checks++;
      if (damage_a !== 8'd20 || heal_a !== 8'd5 || hit_a !== 3'd3 || inv_a !== 1'b1) begin
         errors++;
         $display("FAIL abort_totals: got dmg=%0d heal=%0d hit=%0d inv=%b, want 20/5/3/1",
                  damage_a, heal_a, hit_a, inv_a);
      end
      extra_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (done_a) extra_done++;
      end
      checks++;
      if (extra_done !== 0) begin errors++; $display("FAIL abort_extra_done: got %0d want 0", extra_done); end
   endtask

   task automatic test_reset_mid();
      int lat;
      clear_slots_a();
      set_slot_a(0, 1'b1, 1'b1, 3'd0);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({damage_a, heal_a, hit_a, index_a, busy_a, done_a, inv_a} !== 24'd0) begin
         errors++;
         $display("FAIL reset_mid: got dmg=%0d hit=%0d idx=%0d busy=%b inv=%b, want all 0",
                  damage_a, hit_a, index_a, busy_a, inv_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      scan_a(lat);
      checks++;
      if (lat !== 3 || damage_a !== 8'd10 || hit_a !== 3'd1 || inv_a !== 1'b1) begin
         errors++;
         $display("FAIL reset_recover: got lat=%0d dmg=%0d hit=%0d inv=%b, want 3/10/1/1",
                  lat, damage_a, hit_a, inv_a);
      end
   endtask

   task automatic test_saturate();
      int lat;
      for (int i = 0; i < 8; i++) coll_b[i] = 1'b1;
      for (int r = 0; r < 2; r++) begin
         scan_b(lat);
         checks++;
         if (lat !== 8 || damage_b !== 8'd255 || hit_b !== 4'd8 || heal_b !== 8'd0 || inv_b !== 1'b0) begin
            errors++;
            $display("FAIL saturate_%0d: got lat=%0d dmg=%0d hit=%0d heal=%0d inv=%b, want 8/255/8/0/0",
                     r, lat, damage_b, hit_b, heal_b, inv_b);
         end
      end
   endtask

   initial begin
      clear_slots_a();
      for (int i = 0; i < 8; i++) coll_b[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_basic();
      test_back_to_back();
      test_orange_render();
      test_abort();
      test_reset_mid();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
